// File: rtl/fp_operand_loader.sv
// Byte-serial operand front end for the FP ALU core: packs eight little-endian bytes into two
// single-precision operands, then issues a valid/ready transaction. Optional macro: FP_LOADER_NAN_FLAG_EN.
module fp_operand_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        byte_valid,
  input  logic [1:0]  opcode_in,
  input  logic        start,
  input  logic        core_ready,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [1:0]  opcode,
  output logic        op_valid,
  output logic        err,
  output logic        nan_flag,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_A = 4'd1,
    LOAD_B = 4'd2,
    FULL   = 4'd3,
    ISSUE  = 4'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [1:0]  opc_q, opc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        start_q;
  logic        start_edge;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      IDLE, LOAD_A, LOAD_B: begin
        // An early start flags an error but never blocks byte loading.
        if (start_edge) err_d = 1'b1;
        if (byte_valid) begin
          if (idx_q[2]) opb_d[{idx_q[1:0], 3'b000} +: 8] = in_byte;
          else          opa_d[{idx_q[1:0], 3'b000} +: 8] = in_byte;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7)      state_d = FULL;
          else if (idx_q >= 3'd3) state_d = LOAD_B;
          else                    state_d = LOAD_A;
        end
      end
      FULL: begin
        if (byte_valid) err_d = 1'b1;
        if (start_edge) begin
          opc_d   = opcode_in;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (byte_valid) err_d = 1'b1;
        // A completed handshake clears the sticky error, even one raised this cycle.
        if (core_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      start_q <= start;
    end
  end

`ifdef FP_LOADER_NAN_FLAG_EN
  logic nan_q;
  logic a_nan, b_nan;

  assign a_nan = (opa_q[30:23] == 8'hFF) && (opa_q[22:0] != '0);
  assign b_nan = (opb_q[30:23] == 8'hFF) && (opb_q[22:0] != '0);

  always_ff @(posedge clk) begin
    if (!rst_n)                                  nan_q <= 1'b0;
    else if (state_q == FULL && start_edge)      nan_q <= a_nan | b_nan;
    else if (state_q == ISSUE && core_ready)     nan_q <= 1'b0;
  end

  assign nan_flag = nan_q;
`else
  assign nan_flag = 1'b0;
`endif

  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign opcode    = opc_q;
  assign op_valid  = valid_q;
  assign err       = err_q;
  assign state_out = state_q;

endmodule

// File: doc/fp_operand_loader.md
# fp_operand_loader

Byte-serial operand front end for the 32-bit floating-point ALU core. It sits directly upstream of the core: it assembles two IEEE-754 single-precision operands from eight bytes arriving on the 8-bit input pin bus, latches the opcode on a start request, and issues a valid/ready transaction to the core. It also exposes a 4-bit state code for the debug pins.

## Interface
- No parameters; widths are fixed (8-bit byte bus, 32-bit operands, 2-bit opcode).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous and active-low
- in_byte  input  8  operand byte from the input pins
- byte_valid  input  1  qualifies in_byte; one byte is consumed per cycle it is high
- opcode_in  input  2  operation select; sampled on the accepted start edge
- start  input  1  level from pin; rising edge requests issue
- core_ready  input  1  core can accept an operation this cycle
- operand_a  output  32  assembled operand A
- operand_b  output  32  assembled operand B
- opcode  output  2  latched opcode
- op_valid  output  1  operation offered to core
- err  output  1  sticky protocol error
- nan_flag  output  1  an operand is NaN (see Configuration)
- state_out  output  4  current state code

## Operation
- States and codes: IDLE=0, LOAD_A=1, LOAD_B=2, FULL=3, ISSUE=4. Codes 5–15 are unused and return to IDLE on the next clock.
- Byte order is little-endian. Byte k (0–3) goes to operand_a[8k+7:8k]. Bytes 4–7 go to operand_b in the same way.
- A 3-bit byte counter idx tracks the next byte to load.
- IDLE: byte_valid writes byte 0, sets idx=1 and moves to LOAD_A.
- LOAD_A: each valid byte increments idx. Byte 3 moves to LOAD_B.
- LOAD_B: byte 7 moves to FULL, and idx wraps to 0.
- FULL: a rising edge of start latches opcode_in into opcode, moves to ISSUE and asserts op_valid.
- ISSUE: op_valid stays high and operand_a, operand_b and opcode are held stable until core_ready=1. On the handshake cycle the block returns to IDLE; op_valid drops the next cycle.
- Operands keep their values after the handshake until overwritten by new bytes.
- Start detection: a registered copy of start (start_q). An edge is start=1 and start_q=0. A start held high does not re-trigger.
- err is set, and the state is unchanged, on any of:
  - a start edge in IDLE, LOAD_A or LOAD_B;
  - byte_valid in FULL or ISSUE (the byte is dropped).
- err clears only on reset or on a completed ISSUE handshake.
- Simultaneous events:
  - byte_valid together with a start edge in LOAD_B while loading byte 7: the block goes to FULL and the start is treated as early, setting err.
  - core_ready is ignored outside ISSUE.

## Timing
- All outputs are registered. Reset values: operand_a=0, operand_b=0, opcode=0, op_valid=0, err=0, nan_flag=0, state_out=0. Internally idx=0 and start_q=0.
- Reset applies at any state, including mid-load and in ISSUE. An offered operation is withdrawn (op_valid=0) on the cycle after the reset edge.
- Eight byte_valid cycles fill the operands; back-to-back bytes are accepted every cycle.
- Start edge sampled at edge N gives op_valid=1 after edge N.
- With core_ready already high, the handshake completes at edge N+1, so minimum issue latency is 1 cycle.
- Fastest full transaction from first byte to IDLE is 10 edges.

## Configuration
- FP_LOADER_NAN_FLAG_EN defined:
  - nan_flag is registered with the start-edge transition into ISSUE.
  - It is 1 if either operand has exponent 8'hFF and a non-zero mantissa.
  - It is held through ISSUE and cleared on the handshake.
- FP_LOADER_NAN_FLAG_EN undefined: nan_flag is tied to 0 and no compare logic is built.

## Test plan
- Basic load and issue:
  - Stimulus: bytes 00,00,80,3F,00,00,00,40 with core_ready=1, then a start edge with opcode_in=2'b01.
  - Required: operand_a=32'h3F800000, operand_b=32'h40000000, opcode=01; op_valid high for exactly 1 cycle; state_out sequence 1,1,1,2,2,2,2,3,4,0.
- Backpressure: core_ready=0 for 5 cycles in ISSUE, then 1. Required: op_valid and the operands stay stable for 6 cycles, then state_out=0.
- Early start: start edge after 3 bytes. Required: err=1, state_out stays 1. Loading then continues to FULL; after a good issue, err clears.
- Held start: start stays high through FULL entry without a new edge. Required: no issue. After dropping start and raising it again, ISSUE is entered.
- Mid-operation reset: rst_n=0 for one cycle while in ISSUE with core_ready=0. Required: all outputs are 0 on the next cycle and a fresh load works.
- NaN flag (FP_LOADER_NAN_FLAG_EN defined): operand_b=32'h7FC00000. Required: nan_flag=1 during ISSUE and 0 after the handshake. With the macro undefined, nan_flag is always 0.
